// File: rtl/mem_word_arbiter_if.sv
// mem_word_arbiter_if: IF/MEM requester handshakes and RAM address/strobe shared with the arbiter.
interface mem_word_arbiter_if #(parameter int ADDR_W = 18);
  logic              if_en;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_data;
  logic              if_ack;
  logic              if_stall;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              mem_stall;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wre;
  modport slave (
    input  if_en, if_addr, mem_en, mem_rw, mem_addr, mem_wdata,
    output if_data, if_ack, if_stall, mem_rdata, mem_ack, mem_stall, ram_addr, ram_wre
  );
  modport master (
    output if_en, if_addr, mem_en, mem_rw, mem_addr, mem_wdata,
    input  if_data, if_ack, if_stall, mem_rdata, mem_ack, mem_stall, ram_addr, ram_wre
  );
endinterface

// File: rtl/mem_word_arbiter.sv
// mem_word_arbiter: splits IF/MEM 32-bit requests into two 16-bit RAM accesses, MEM has strict priority.
module mem_word_arbiter #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_word_arbiter_if.slave bus,
  inout  wire  [15:0]       ram_data_io
);
  typedef enum logic [1:0] {IDLE, LO, HI, ACK} state_t;
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [15:0]       rd_lo_q;
  logic [31:0]       if_data_q, mem_rdata_q;
  logic              drive;
  // owner_q: 1 = MEM, 0 = IF; the addr MSB is never latched since it does not reach the RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      rd_q        <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (state_q == LO && rd_q) rd_lo_q <= ram_data_io;
      if (state_q == HI && rd_q && owner_q) mem_rdata_q <= {ram_data_io, rd_lo_q};
      if (state_q == HI && rd_q && !owner_q) if_data_q <= {ram_data_io, rd_lo_q};
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? ((bus.mem_en | bus.if_en) ? LO : IDLE) :
              state_q == LO   ? HI :
              state_q == HI   ? ACK : IDLE;
    owner_d = owner_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && (bus.mem_en | bus.if_en)) begin
      owner_d = bus.mem_en;
      rd_d    = bus.mem_en ? bus.mem_rw : 1'b1;
      addr_d  = bus.mem_en ? bus.mem_addr[ADDR_W-2:0] : bus.if_addr[ADDR_W-2:0];
      wdata_d = bus.mem_wdata;
    end
  end
  assign drive         = (state_q == LO || state_q == HI) && !rd_q;
  assign ram_data_io   = drive ? (state_q == HI ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
  assign bus.ram_wre   = !drive;
  assign bus.ram_addr  = {addr_q, state_q == HI || state_q == ACK};
  assign bus.if_ack    = state_q == ACK && !owner_q;
  assign bus.mem_ack   = state_q == ACK && owner_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_stall  = bus.if_en & !bus.if_ack;
  assign bus.mem_stall = bus.mem_en & !bus.mem_ack;
endmodule
